// File: rtl/btn_event_fsm.sv
// -----------------------------------------------------------------------------
// btn_event_fsm
// Classifies a debounced button level into one-cycle event pulses: press,
// release, single click, double click and long press. A local prescaler
// produces a tick every TICK_DIV clocks. An interval counter counts ticks
// since the last state change, so every timeout is measured from state entry.
//
// Ports
//   clk          in   system clock, rising edge active
//   rst_n        in   asynchronous active-low reset
//   db           in   debounced button level, 1 = pressed
//   press_p      out  one-cycle pulse on each accepted press
//   release_p    out  one-cycle pulse on each release
//   click_p      out  one-cycle pulse for a single short click
//   dbl_click_p  out  one-cycle pulse for a double click
//   long_p       out  one-cycle pulse when the long-press threshold is reached
//   held         out  level, 1 while in LONG_HOLD
// -----------------------------------------------------------------------------
module btn_event_fsm #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned LONG_TICKS = 1000,
    parameter int unsigned DBL_TICKS  = 250,
    parameter int unsigned CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic dbl_click_p,
    output logic long_p,
    output logic held
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_t           state_q, state_d;
    logic             db_q;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, click_d, dbl_d, long_d, held_d;

    logic rise_s, fall_s, tick_s, long_to_s, dbl_to_s, trans_s;

    // Edge, tick and timeout qualifiers derived from the current registers.
    always_comb begin
        rise_s    = db & ~db_q;
        fall_s    = ~db & db_q;
        tick_s    = (presc_q == TICK_LAST);
        // Timeout N lands on the Nth tick after state entry (counter reads N-1).
        long_to_s = tick_s && (cnt_q == LONG_LAST);
        dbl_to_s  = tick_s && (cnt_q == DBL_LAST);
    end

    // Next-state and pulse decode. A db edge always takes priority over a timeout.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dbl_d     = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_PRESS1;
                    press_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (fall_s) begin
                    state_d   = ST_WAIT2;
                    release_d = 1'b1;
                end else if (long_to_s) begin
                    state_d = ST_LONG_HOLD;
                    long_d  = 1'b1;
                end else begin
                    state_d = ST_PRESS1;
                end
            end
            ST_LONG_HOLD: begin
                if (fall_s) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else begin
                    state_d = ST_LONG_HOLD;
                end
            end
            ST_WAIT2: begin
                if (rise_s) begin
                    state_d = ST_PRESS2;
                    press_d = 1'b1;
                end else if (dbl_to_s) begin
                    state_d = ST_IDLE;
                    click_d = 1'b1;
                end else begin
                    state_d = ST_WAIT2;
                end
            end
            ST_PRESS2: begin
                if (fall_s) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    dbl_d     = 1'b1;
                end else if (long_to_s) begin
                    // The pending first click is dropped in favour of the long press.
                    state_d = ST_LONG_HOLD;
                    long_d  = 1'b1;
                end else begin
                    state_d = ST_PRESS2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        held_d = (state_d == ST_LONG_HOLD);
    end

    // Prescaler and saturating interval counter, both restarted on any state change.
    always_comb begin
        trans_s = (state_d != state_q);
        if (trans_s) begin
            presc_d = CNT_ZERO;
            cnt_d   = CNT_ZERO;
        end else begin
            presc_d = tick_s ? CNT_ZERO : (presc_q + CNT_ONE);
            if (tick_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // State, counters, edge history and registered outputs.
    // db_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            db_q        <= 1'b1;
            presc_q     <= CNT_ZERO;
            cnt_q       <= CNT_ZERO;
            press_p     <= 1'b0;
            release_p   <= 1'b0;
            click_p     <= 1'b0;
            dbl_click_p <= 1'b0;
            long_p      <= 1'b0;
            held        <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_q        <= db;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            press_p     <= press_d;
            release_p   <= release_d;
            click_p     <= click_d;
            dbl_click_p <= dbl_d;
            long_p      <= long_d;
            held        <= held_d;
        end
    end

endmodule

// File: tb/tb_btn_event_fsm.sv
// -----------------------------------------------------------------------------
// tb_btn_event_fsm
// Directed bench for btn_event_fsm with TICK_DIV=4, LONG_TICKS=10, DBL_TICKS=5.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so a pulse caused by edge k is seen right after edge k.
// -----------------------------------------------------------------------------
module tb_btn_event_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic db = 1'b0;
    logic press_p, release_p, click_p, dbl_click_p, long_p, held;

    btn_event_fsm #(
        .TICK_DIV(4),
        .LONG_TICKS(10),
        .DBL_TICKS(5),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .db(db),
        .press_p(press_p),
        .release_p(release_p),
        .click_p(click_p),
        .dbl_click_p(dbl_click_p),
        .long_p(long_p),
        .held(held)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int n_press, n_rel, n_click, n_dbl, n_long, n_held;
    int t_press, t_rel, t_click, t_dbl, t_long, t_held_first, t_held_last;

    task automatic clear_mon();
        n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0; n_held = 0;
        t_press = -1; t_rel = -1; t_click = -1; t_dbl = -1; t_long = -1;
        t_held_first = -1; t_held_last = -1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (press_p)     begin n_press++; t_press = cyc; end
            if (release_p)   begin n_rel++;   t_rel   = cyc; end
            if (click_p)     begin n_click++; t_click = cyc; end
            if (dbl_click_p) begin n_dbl++;   t_dbl   = cyc; end
            if (long_p)      begin n_long++;  t_long  = cyc; end
            if (held) begin
                if (n_held == 0) t_held_first = cyc;
                n_held++;
                t_held_last = cyc;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_low(input string tag);
        check(tag, {26'd0, press_p, release_p, click_p, dbl_click_p, long_p, held}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        // ---------------- reset state ----------------
        #1;
        check_all_low("reset_outputs");
        run(2);
        check("reset_state", {29'd0, dut.state_q}, 32'd0);
        check("reset_presc", {16'd0, dut.presc_q}, 32'd0);
        check("reset_cnt",   {16'd0, dut.cnt_q},   32'd0);
        rst_n = 1'b1;
        run(3);
        check_all_low("idle_outputs");

        // ---------------- single click ----------------
        clear_mon();
        db = 1'b1;
        run(1);
        check("click_press_latency", {31'd0, press_p}, 32'd1);
        run(11);
        db = 1'b0;
        run(1);
        check("click_release_latency", {31'd0, release_p}, 32'd1);
        run(25);
        check("click_count", n_click, 32'd1);
        check("click_delay", t_click - t_rel, 32'd20);
        check("click_no_dbl", n_dbl, 32'd0);
        check("click_no_long", n_long, 32'd0);
        check("click_press_count", n_press, 32'd1);

        // ---------------- double click ----------------
        clear_mon();
        db = 1'b1; run(12);
        db = 1'b0; run(8);
        db = 1'b1; run(12);
        db = 1'b0; run(30);
        check("dbl_press_count", n_press, 32'd2);
        check("dbl_release_count", n_rel, 32'd2);
        check("dbl_count", n_dbl, 32'd1);
        check("dbl_with_release", t_dbl, t_rel);
        check("dbl_no_click", n_click, 32'd0);
        check("dbl_no_long", n_long, 32'd0);

        // ---------------- long press ----------------
        clear_mon();
        db = 1'b1; run(60);
        db = 1'b0; run(30);
        check("long_count", n_long, 32'd1);
        check("long_delay", t_long - t_press, 32'd40);
        check("held_first", t_held_first, t_long);
        check("held_cycles", n_held, 32'd20);
        check("held_drop_at_release", t_rel - t_held_last, 32'd1);
        check("long_release_count", n_rel, 32'd1);
        check("long_no_click", n_click, 32'd0);

        // ---------------- fall exactly at long timeout ----------------
        clear_mon();
        db = 1'b1; run(40);
        db = 1'b0; run(1);
        check("p1tie_release", {31'd0, release_p}, 32'd1);
        check("p1tie_no_long", {31'd0, long_p}, 32'd0);
        check("p1tie_state_wait2", {29'd0, dut.state_q}, 32'd2);
        run(25);
        check("p1tie_click", n_click, 32'd1);
        check("p1tie_long_total", n_long, 32'd0);

        // ---------------- rise exactly at double-click timeout ----------------
        clear_mon();
        db = 1'b1; run(12);
        db = 1'b0; run(1);
        run(19);
        db = 1'b1; run(1);
        check("w2tie_press", {31'd0, press_p}, 32'd1);
        check("w2tie_no_click", {31'd0, click_p}, 32'd0);
        check("w2tie_state_press2", {29'd0, dut.state_q}, 32'd3);
        run(5);
        db = 1'b0; run(30);
        check("w2tie_click_total", n_click, 32'd0);
        check("w2tie_dbl", n_dbl, 32'd1);

        // ---------------- reset while held ----------------
        db = 1'b1;
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        clear_mon();
        run(50);
        check("rsthold_no_press", n_press, 32'd0);
        check("rsthold_no_long", n_long, 32'd0);
        check("rsthold_no_held", n_held, 32'd0);
        check("rsthold_no_pulses", n_rel + n_click + n_dbl, 32'd0);
        check("rsthold_state_idle", {29'd0, dut.state_q}, 32'd0);
        db = 1'b0; run(2);
        db = 1'b1; run(1);
        check("rsthold_new_press", {31'd0, press_p}, 32'd1);
        run(3);
        db = 1'b0; run(30);

        // ---------------- reset mid-WAIT2 ----------------
        clear_mon();
        db = 1'b1; run(12);
        db = 1'b0; run(1);
        check("rstw2_release", {31'd0, release_p}, 32'd1);
        run(10);
        rst_n = 1'b0;
        #1;
        check("rstw2_state", {29'd0, dut.state_q}, 32'd0);
        check("rstw2_presc", {16'd0, dut.presc_q}, 32'd0);
        check("rstw2_cnt",   {16'd0, dut.cnt_q},   32'd0);
        check_all_low("rstw2_outputs");
        run(2);
        rst_n = 1'b1;
        clear_mon();
        run(30);
        check("rstw2_no_click", n_click, 32'd0);
        check("rstw2_idle", {29'd0, dut.state_q}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_event_fsm.md
Name: btn_event_fsm

Overview:
- Consumes the debounced level `db` from the switch debouncer and classifies it into one-cycle event pulses: press, release, single click, double click and long press.
- Sits directly downstream of the debouncer and upstream of the control/UI logic, so that logic never times button activity itself.
- Contains its own millisecond prescaler, a state machine and an interval counter.

Parameters:
- TICK_DIV, 50000, clk cycles per time tick (1 ms at 50 MHz); must be >= 2.
- LONG_TICKS, 1000, number of ticks a press must be held to count as a long press.
- DBL_TICKS, 250, maximum gap in ticks between release and the next press for a double click.
- CNT_W, 16, width of the prescaler and interval counters; TICK_DIV, LONG_TICKS and DBL_TICKS must each be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- db  in  1  debounced button level, synchronous to clk; 1 = pressed.
- press_p  out  1  one-cycle pulse on each accepted press.
- release_p  out  1  one-cycle pulse on each release.
- click_p  out  1  one-cycle pulse for a single short click.
- dbl_click_p  out  1  one-cycle pulse for a double click.
- long_p  out  1  one-cycle pulse when the long-press threshold is reached.
- held  out  1  level output; 1 while in LONG_HOLD.

Behaviour:
- **Reset (rst_n = 0, asynchronous):**
  - State goes to IDLE; all outputs go to 0; prescaler and interval counter go to 0.
  - db_d resets to 1. A button already held when reset releases therefore produces no press; it must be released and pressed again.
  - Reset mid-operation aborts any pending click, double click or long press with no pulse.
- **Edge detection:**
  - db_d <= db every edge.
  - rise = db & ~db_d; fall = ~db & db_d.
- **Outputs:**
  - All outputs are registered.
  - Each pulse is high for exactly the one cycle after the clk edge at which its condition is true.
  - Latency from a db change to press_p or release_p is 1 cycle.
  - More than one pulse may assert in the same cycle.
- **Tick timebase:**
  - The prescaler counts 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1).
  - The prescaler wraps to 0 after each tick.
  - The interval counter increments on tick and saturates at 2^CNT_W-1.
  - On every state transition, both the prescaler and the interval counter clear to 0.
  - A threshold of N ticks is therefore reached exactly N*TICK_DIV cycles after state entry.
  - "Timeout N" means: tick, and interval counter == N-1, at the same edge.
- **States and transitions** (3-bit encoding; any unused or illegal code goes to IDLE):
  - IDLE: on rise -> PRESS1, pulse press_p. Otherwise stay.
  - PRESS1:
    - fall -> WAIT2, pulse release_p.
    - timeout LONG_TICKS -> LONG_HOLD, pulse long_p.
  - LONG_HOLD: held = 1. On fall -> IDLE, pulse release_p. No click is generated.
  - WAIT2:
    - rise -> PRESS2, pulse press_p.
    - timeout DBL_TICKS -> IDLE, pulse click_p.
  - PRESS2:
    - fall -> IDLE, pulse release_p and dbl_click_p together.
    - timeout LONG_TICKS -> LONG_HOLD, pulse long_p. The first click is discarded, so no click_p.
- **Simultaneous events:** when an edge of db and a timeout fall on the same clk edge, the db edge wins and the timeout is ignored. Examples:
  - WAIT2 with rise at the timeout -> PRESS2, no click_p.
  - PRESS1 with fall at the timeout -> WAIT2, no long_p.
- **Edges with no transition:** db edges not listed above cannot occur if db is legal (e.g. rise in PRESS1). They cause no transition and no pulse.
- **Click cadence:** click_p is delayed by DBL_TICKS*TICK_DIV cycles after release_p. This delay is required, not an artefact.

Test Plan:
(All cases use TICK_DIV=4, LONG_TICKS=10, DBL_TICKS=5.)
- **Single click:** db 0->1 for 12 cycles, then 0.
  - press_p is 1 cycle after the rise; release_p is 1 cycle after the fall.
  - click_p asserts exactly 20 cycles after the release edge.
  - No dbl_click_p, no long_p.
- **Double click:** high 12, low 8, high 12, low.
  - press_p x2, release_p x2; dbl_click_p coincides with the second release_p.
  - click_p never asserts.
- **Long press:** db high for 60 cycles.
  - long_p fires 40 cycles after the press edge; held = 1 from that cycle until 1 cycle after the fall.
  - release_p fires on release; no click_p.
- **Tie-break at DBL timeout:** second rise lands on the edge where WAIT2 would time out (20 cycles after the release edge).
  - The FSM enters PRESS2 with press_p; click_p stays 0.
- **Reset while held:** db held at 1 through rst_n pulse, then kept high for 50 cycles.
  - No press_p, no long_p, all outputs 0.
  - A subsequent 0->1 on db produces press_p normally.
- **Reset mid-WAIT2:** rst_n asserted 10 cycles after a release.
  - No click_p afterwards; the FSM is in IDLE and all counters read 0.
